// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: core request/response handshake plus
// the word-wide memory port with four little-endian byte lanes.
interface load_store_unit_if #(
  parameter int XLEN = 32
);

  // Core request channel
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  // Core response channel
  logic            resp_valid;
  logic            resp_err;
  logic [XLEN-1:0] resp_rdata;

  // Memory port; lane k is the byte at word base + k
  logic [XLEN-1:0] mem_addr;
  logic [3:0][7:0] mem_data_out;
  logic [3:0][7:0] mem_data_in;
  logic            mem_write_en;

  // The load/store unit itself
  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  mem_data_out,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_addr, mem_data_in, mem_write_en
  );

  // The environment: core plus memory
  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output mem_data_out,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_addr, mem_data_in, mem_write_en
  );

endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Loads wait a fixed memory latency and
// extract/extend the addressed bytes; word stores write directly; byte and
// half stores read the word first, merge the new bytes and write it back.
// Misaligned requests complete immediately with an error and no memory access.
module load_store_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 4
) (
  input logic              clk,
  input logic              rst_b,
  load_store_unit_if.slave bus
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;

  // Latched request fields
  logic            op_store;
  logic            op_signed;
  logic [1:0]      op_size;
  logic [1:0]      op_off;
  logic [15:0]     op_wdata;

  // Registered outputs
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0][7:0] wr_lanes_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  logic            misaligned;
  logic            rd_last;

  // Size 11 behaves as a word, so bit 1 alone identifies a word access.
  assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  assign rd_last = (state == RD_WAIT) && (cnt == '0);

  // Extract the addressed byte/half from the read word and extend it.
  function automatic logic [XLEN-1:0] load_value(
    input logic [3:0][7:0] lanes,
    input logic [1:0]      size,
    input logic [1:0]      off,
    input logic            sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [1:0]  off_hi;
    off_hi = off + 2'd1;
    b      = lanes[off];
    h      = {lanes[off_hi], lanes[off]};
    case (size)
      2'b00:   load_value = {{(XLEN-8){sgn & b[7]}}, b};
      2'b01:   load_value = {{(XLEN-16){sgn & h[15]}}, h};
      default: load_value = XLEN'(lanes);
    endcase
  endfunction

  // Replace the addressed lanes of the read word with the store bytes.
  function automatic logic [3:0][7:0] merge_lanes(
    input logic [3:0][7:0] lanes,
    input logic [1:0]      size,
    input logic [1:0]      off,
    input logic [15:0]     wdata
  );
    logic [1:0] off_hi;
    off_hi      = off + 2'd1;
    merge_lanes = lanes;
    merge_lanes[off] = wdata[7:0];
    if (size == 2'b01) merge_lanes[off_hi] = wdata[15:8];
  endfunction

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst_b) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode for the access sequence.
  // NOTE: state_nxt is defaulted first so no path through the case can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned)                       state_nxt = RESP;
          else if (!bus.req_store)              state_nxt = RD_WAIT;
          else if (bus.req_size[1])             state_nxt = WR;
          else                                  state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) state_nxt = op_store ? WR : RESP;
      end
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency counter, read sampling, merge and result registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt          <= '0;
      op_store     <= 1'b0;
      op_signed    <= 1'b0;
      op_size      <= 2'b00;
      op_off       <= 2'b00;
      op_wdata     <= '0;
      mem_addr_q   <= '0;
      wr_lanes_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_store  <= bus.req_store;
            op_signed <= bus.req_signed;
            op_size   <= bus.req_size;
            op_off    <= bus.req_addr[1:0];
            op_wdata  <= bus.req_wdata[15:0];
            cnt       <= CW'(MEM_LATENCY - 1);
            if (misaligned) begin
              // Error completes next cycle; the memory port is left untouched.
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              mem_addr_q <= {bus.req_addr[XLEN-1:2], 2'b00};
              if (bus.req_store && bus.req_size[1])
                wr_lanes_q <= bus.req_wdata[31:0];
            end
          end
        end
        RD_WAIT: begin
          if (!rd_last) begin
            cnt <= cnt - CW'(1);
          end else if (op_store) begin
            wr_lanes_q <= merge_lanes(bus.mem_data_out, op_size, op_off, op_wdata);
          end else begin
            resp_rdata_q <= load_value(bus.mem_data_out, op_size, op_off, op_signed);
            resp_err_q   <= 1'b0;
          end
        end
        WR: begin
          // Stores report zero data and no error.
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.resp_valid   = (state == RESP);
  assign bus.mem_write_en = (state == WR);
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_in  = wr_lanes_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit. A byte-level reference
// memory predicts each response and memory write; a monitor compares them
// whenever the DUT presents a write or a response.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int LAT  = 4;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  resp_t rq[$];
  wr_t   wq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit_if #(.XLEN(XLEN)) bus();

  load_store_unit #(.XLEN(XLEN), .MEM_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  // Memory attached to the DUT: 64 words covering 0x100..0x1FF.
  logic [31:0] mem [0:63];
  assign bus.mem_data_out = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr[7:2]] <= bus.mem_data_in;

  // Reference model state: byte-addressed image plus last driven word address.
  logic [7:0]  rb [0:255];
  logic [31:0] last_addr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void init_word(input int idx, input logic [31:0] w);
    mem[idx] = w;
    for (int k = 0; k < 4; k++) rb[idx*4 + k] = w[8*k +: 8];
  endfunction

  // Predict the outcome of one request accepted at the edge after cycle 'acc'.
  task automatic model(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input int acc);
    int          n;
    resp_t       r;
    wr_t         w;
    logic [31:0] base;
    logic [31:0] val;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r.err   = 1'b0;
    r.rdata = 32'h0;
    if ((ad % n) != 0) begin
      r.err  = 1'b1;
      r.cyc  = acc + 1;
      r.addr = last_addr;
    end else begin
      base      = ad & ~32'd3;
      last_addr = base;
      r.addr    = base;
      if (!st) begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(rb[8'(ad + i)]) << (8*i));
        if (sg && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
        r.rdata = val;
        r.cyc   = acc + LAT + 1;
      end else begin
        for (int i = 0; i < n; i++) rb[8'(ad + i)] = 8'(wd >> (8*i));
        w.addr = base;
        w.data = {rb[8'(base+3)], rb[8'(base+2)], rb[8'(base+1)], rb[8'(base)]};
        w.cyc  = acc + ((n == 4) ? 1 : LAT + 1);
        wq.push_back(w);
        r.cyc  = w.cyc + 1;
      end
    end
    rq.push_back(r);
  endtask

  // Drive one request; while the unit is busy, random ignored requests are driven.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    int guard = 0;
    while (bus.req_ready !== 1'b1) begin
      bus.req_valid  = 1'($urandom);
      bus.req_store  = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = 32'h100 + 32'($urandom_range(0, 63));
      bus.req_wdata  = $urandom;
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        check("ready_timeout", bus.req_ready, 1'b1);
        bus.req_valid = 1'b0;
        return;
      end
    end
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    model(st, sz, sg, ad, wd, cyc);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((rq.size() != 0 || wq.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_pending", 64'(rq.size() + wq.size()), 64'd0);
  endtask

  // Monitor: compare every memory write and every response against the queues.
  initial begin
    wr_t   w;
    resp_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_write_en) begin
          if (wq.size() == 0) check("unexpected_write", bus.mem_write_en, 1'b0);
          else begin
            w = wq.pop_front();
            check("wr_cycle", 64'(cyc), 64'(w.cyc));
            check("wr_addr",  bus.mem_addr, w.addr);
            check("wr_data",  bus.mem_data_in, w.data);
          end
        end
        if (bus.resp_valid) begin
          if (rq.size() == 0) check("unexpected_resp", bus.resp_valid, 1'b0);
          else begin
            r = rq.pop_front();
            check("resp_cycle", 64'(cyc), 64'(r.cyc));
            check("resp_err",   bus.resp_err, r.err);
            check("resp_rdata", bus.resp_rdata, r.rdata);
            check("resp_mem_addr", bus.mem_addr, r.addr);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] saved;
    int          acc;

    for (int i = 0; i < 64; i++) init_word(i, $urandom);
    init_word(0, 32'h4483_2211);   // lanes {0x11,0x22,0x83,0x44} at 0x100

    // Reset with a coincident request that must be ignored.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h104;
    bus.req_wdata  = 32'h1234_5678;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready",   bus.req_ready,    1'b1);
    check("rst_resp_valid",  bus.resp_valid,   1'b0);
    check("rst_resp_err",    bus.resp_err,     1'b0);
    check("rst_resp_rdata",  bus.resp_rdata,   32'h0);
    check("rst_mem_we",      bus.mem_write_en, 1'b0);
    check("rst_mem_addr",    bus.mem_addr,     32'h0);
    check("rst_mem_data_in", bus.mem_data_in,  32'h0);
    rst_b = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("req_ignored_in_reset", bus.req_ready, 1'b1);
    mon_en = 1'b1;

    // Directed vectors against the reference image.
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);          // lw  -> 0x44832211 @5
    issue(1'b0, 2'b00, 1'b1, 32'h102, 32'h0);          // lb  -> 0xFFFFFF83
    issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);          // lbu -> 0x00000083
    issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);          // lh  -> 0x00004483
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD);  // sh  write @5, resp @6
    issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF);  // sw  write @1, resp @2
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);          // misaligned lw, err @1
    issue(1'b0, 2'b11, 1'b0, 32'h106, 32'h0);          // size 11 misaligned as word
    issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0);          // misaligned half
    drain();
    check("mem_after_sh", mem[0], 32'hABCD_2211);
    check("mem_after_sw", mem[1], 32'hDEAD_BEEF);

    // Randomized traffic, with idle gaps.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(1'(($urandom)), 2'($urandom), 1'($urandom),
            32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end
    drain();

    // Byte store abandoned by reset during its read phase.
    saved = mem[0];
    while (bus.req_ready !== 1'b1) @(negedge clk);
    acc = cyc;
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h0000_0055;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (cyc < acc + 3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("abort_ready_cycle4", bus.req_ready,    1'b1);
    check("abort_no_resp",      bus.resp_valid,   1'b0);
    check("abort_no_write",     bus.mem_write_en, 1'b0);
    check("abort_mem_addr",     bus.mem_addr,     32'h0);
    check("abort_mem_data_in",  bus.mem_data_in,  32'h0);
    repeat (10) @(negedge clk);
    check("abort_mem_intact", mem[0], saved);
    check("abort_still_idle", bus.req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
